// File: rtl/formation_pkg.sv
// formation_pkg: shared types and constants for the sprite formation controller.
//   state_t      - formation state (march / landed / cleared)
//   IDX_*        - sprite index into the hit/alive vectors
//   PARK         - coordinate driven for destroyed sprites
//   span()       - pixel width of the whole formation, fixed regardless of kills
package formation_pkg;

  typedef enum logic [1:0] {
    ST_MARCH   = 2'd0,
    ST_LANDED  = 2'd1,
    ST_CLEARED = 2'd2
  } state_t;

  localparam int NUM_SPRITES = 5;
  localparam int IDX_I  = 0;
  localparam int IDX_G  = 1;
  localparam int IDX_U1 = 2;
  localparam int IDX_U2 = 3;
  localparam int IDX_U3 = 4;

  // Far enough off-screen to hide the sprite, small enough that shape
  // offsets added downstream cannot wrap a 32-bit coordinate.
  localparam logic [31:0] PARK = 32'd16384;

  // Five sprites: four gaps plus the last sprite's width.
  function automatic logic [31:0] span(input logic [31:0] spacing,
                                       input logic [31:0] width);
    return (spacing << 2) + width;
  endfunction

endpackage

// File: rtl/formation_step.sv
// step_timer: frame divider for the formation march.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_load        - reinitialise counter and period (restart)
//   i_tick        - one pulse per frame
//   i_en          - movement enable; counter holds while low
//   i_run         - formation is marching; counter holds otherwise
//   i_dec         - shorten the period by one frame (floor 1)
//   o_step        - one-cycle pulse on the frame that completes a period
module step_timer #(
  parameter int PERIOD_INIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_run,
  input  logic i_dec,
  output logic o_step
);

  logic [3:0] r_cnt;
  logic [3:0] r_period;
  logic       w_fire;

  assign w_fire = i_tick & i_en & i_run;
  // Combinational so the caller registers the move on the tick's own edge.
  assign o_step = w_fire && (r_cnt == r_period - 4'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt    <= 4'd0;
      r_period <= 4'(PERIOD_INIT);
    end else begin
      if (w_fire) r_cnt <= o_step ? 4'd0 : r_cnt + 4'd1;
      if (i_dec && r_period > 4'd1) r_period <= r_period - 4'd1;
    end
  end

endmodule

// File: rtl/formation_controller.sv
// formation_controller: marches five glyph sprites across the playfield.
//   CLOCK_50    - system clock
//   reset       - synchronous active-high reset
//   frame_tick  - one pulse per frame
//   enable      - movement enable
//   restart     - reinitialise formation (any state)
//   hit[4:0]    - per-sprite kill pulses (0=i,1=g,2=u1,3=u2,4=u3)
//   *X1/*Y1     - sprite top-left coordinates, PARK when dead
//   alive       - live mask
//   dir         - 1 = moving right
//   landed      - formation reached Y_LIMIT
//   cleared     - all sprites destroyed
module formation_controller
  import formation_pkg::*;
#(
  parameter int unsigned X_START     = 40,
  parameter int unsigned Y_START     = 40,
  parameter int unsigned X_LEFT      = 0,
  parameter int unsigned X_RIGHT     = 640,
  parameter int unsigned SPACING     = 80,
  parameter int unsigned SPRITE_W    = 60,
  parameter int unsigned STEP        = 4,
  parameter int unsigned DROP        = 16,
  parameter int unsigned Y_LIMIT     = 400,
  parameter int unsigned PERIOD_INIT = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        restart,
  input  logic [4:0]  hit,
  output logic [31:0] iX1,
  output logic [31:0] iY1,
  output logic [31:0] gX1,
  output logic [31:0] gY1,
  output logic [31:0] u1X1,
  output logic [31:0] u1Y1,
  output logic [31:0] u2X1,
  output logic [31:0] u2Y1,
  output logic [31:0] u3X1,
  output logic [31:0] u3Y1,
  output logic [4:0]  alive,
  output logic        dir,
  output logic        landed,
  output logic        cleared
);

  localparam logic [31:0] L_SPAN  = span(32'(SPACING), 32'(SPRITE_W));
  localparam logic [31:0] L_STEP  = 32'(STEP);
  localparam logic [31:0] L_DROP  = 32'(DROP);
  localparam logic [31:0] L_RIGHT = 32'(X_RIGHT);
  localparam logic [31:0] L_LEFT  = 32'(X_LEFT);
  localparam logic [31:0] L_YLIM  = 32'(Y_LIMIT);

  logic [31:0] r_form_x, r_form_y;
  logic        r_dir, r_landed, r_cleared;
  logic [4:0]  r_alive;
  state_t      r_state;

  logic        w_step, w_edge, w_drop;
  logic [31:0] w_new_y;
  logic [4:0]  w_alive_nx;
  logic [NUM_SPRITES-1:0][31:0] w_x, w_y;

  step_timer #(.PERIOD_INIT(PERIOD_INIT)) u_timer (
    .i_clk  (CLOCK_50),
    .i_rst  (reset),
    .i_load (restart),
    .i_tick (frame_tick),
    .i_en   (enable),
    .i_run  (r_state == ST_MARCH),
    .i_dec  (w_drop),
    .o_step (w_step)
  );

  // Edge test uses the full span even when end sprites are dead.
  assign w_edge     = r_dir ? (r_form_x + L_STEP + L_SPAN > L_RIGHT)
                            : (r_form_x < L_LEFT + L_STEP);
  assign w_drop     = w_step & w_edge;
  assign w_new_y    = r_form_y + L_DROP;
  assign w_alive_nx = r_alive & ~hit;

  always_ff @(posedge CLOCK_50) begin
    if (reset || restart) begin
      r_form_x  <= 32'(X_START);
      r_form_y  <= 32'(Y_START);
      r_dir     <= 1'b1;
      r_alive   <= 5'b11111;
      r_state   <= ST_MARCH;
      r_landed  <= 1'b0;
      r_cleared <= 1'b0;
    end else begin
      r_alive <= w_alive_nx;
      if (w_step) begin
        if (w_drop) begin
          r_form_y <= w_new_y;
          r_dir    <= ~r_dir;
        end else begin
          r_form_x <= r_dir ? r_form_x + L_STEP : r_form_x - L_STEP;
        end
      end
      // Losing the last sprite wins over landing in the same cycle.
      if (w_alive_nx == 5'd0) begin
        r_state   <= ST_CLEARED;
        r_landed  <= 1'b0;
        r_cleared <= 1'b1;
      end else if (w_drop && w_new_y >= L_YLIM) begin
        r_state  <= ST_LANDED;
        r_landed <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_spr
    assign w_x[k] = r_alive[k] ? r_form_x + 32'(k * SPACING) : PARK;
    assign w_y[k] = r_alive[k] ? r_form_y : PARK;
  end

  assign iX1  = w_x[IDX_I];
  assign iY1  = w_y[IDX_I];
  assign gX1  = w_x[IDX_G];
  assign gY1  = w_y[IDX_G];
  assign u1X1 = w_x[IDX_U1];
  assign u1Y1 = w_y[IDX_U1];
  assign u2X1 = w_x[IDX_U2];
  assign u2Y1 = w_y[IDX_U2];
  assign u3X1 = w_x[IDX_U3];
  assign u3Y1 = w_y[IDX_U3];

  assign alive   = r_alive;
  assign dir     = r_dir;
  assign landed  = r_landed;
  assign cleared = r_cleared;

endmodule
